sm_hex_display_mux: RTL and testbench

SM_HEX_DISPLAY_MUX -- requirements
Module: sm_hex_display_mux

---
 rtl/sm_hex_display_mux_if.sv | 18 +
 rtl/sm_hex_display_mux.sv | 180 ++++++++++++++++++
 tb/tb_sm_hex_display_mux.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/sm_hex_display_mux_if.sv
// Display pin bundle for the hex display multiplexer.
// master drives seven_segments/dot/anodes/frame_tick; slave observes them.
interface sm_hex_display_mux_if #(
    parameter int DIGITS = 8
);
    logic [6:0]        seven_segments;
    logic              dot;
    logic [DIGITS-1:0] anodes;
    logic              frame_tick;

    modport master (
        output seven_segments, dot, anodes, frame_tick
    );

    modport slave (
        input seven_segments, dot, anodes, frame_tick
    );
endinterface

// File: rtl/sm_hex_display_mux.sv
// Time-multiplexed hex display driver with frame snapshot and lz blanking.
// clkIn/rst_n/enable, number/dots/lz_blank in; disp (master) carries pins.
module sm_hex_display_mux #(
    parameter int DIGITS       = 8,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 8,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                  clkIn,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [4*DIGITS-1:0]   number,
    input  logic [DIGITS-1:0]     dots,
    input  logic                  lz_blank,
    sm_hex_display_mux_if.master  disp
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = $clog2(PRESCALE);
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
    localparam logic [PW-1:0] LAST_PRE = PW'(PRESCALE - 1);
    localparam logic POL = (ACTIVE_LOW != 0);

    typedef enum logic {
        ST_OFF,
        ST_RUN
    } state_t;

    state_t              state_q, state_d;
    logic                load;
    logic [PW-1:0]       pre_q;
    logic [IW-1:0]       idx_q;
    logic [4*DIGITS-1:0] num_q;
    logic [DIGITS-1:0]   dots_q;
    logic                lz_q;

    logic [6:0]          seg_q;
    logic                dot_q;
    logic [DIGITS-1:0]   an_q;
    logic                tick_q;

    logic                wrap;
    logic [4*DIGITS-1:0] src_num;
    logic [DIGITS-1:0]   src_dots;
    logic                src_lz;
    logic [3:0]          nib;
    logic                dsel;
    logic                nz;
    logic                blank;
    logic                gap;
    logic [6:0]          seg_on;
    logic                dot_on;
    logic [DIGITS-1:0]   an_on;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        unique case (v)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            4'hF: g = 7'h71;
        endcase
        return g;
    endfunction

    assign wrap = (pre_q == LAST_PRE) && (idx_q == LAST_IDX);

    // OFF -> RUN on the first enabled edge takes a fresh snapshot;
    // in RUN the snapshot is retaken as the index wraps back to 0.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            ST_OFF: begin
                if (enable) begin
                    state_d = ST_RUN;
                    load    = 1'b1;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_OFF;
                end else if (wrap) begin
                    load = 1'b1;
                end
            end
        endcase
    end

    // The shadows are still stale on the first enabled edge, so that
    // edge decodes straight from the live inputs it is capturing.
    assign src_num  = (state_q == ST_OFF) ? number   : num_q;
    assign src_dots = (state_q == ST_OFF) ? dots     : dots_q;
    assign src_lz   = (state_q == ST_OFF) ? lz_blank : lz_q;

    always_comb begin
        nib   = 4'h0;
        dsel  = 1'b0;
        nz    = 1'b0;
        an_on = '0;
        for (int j = 0; j < DIGITS; j++) begin
            if (j == int'(idx_q)) begin
                nib      = src_num[j*4 +: 4];
                dsel     = src_dots[j];
                an_on[j] = 1'b1;
            end
            if (j >= int'(idx_q) && src_num[j*4 +: 4] != 4'h0) begin
                nz = 1'b1;
            end
        end
        gap = (int'(pre_q) < BLANK_CYCLES);
        if (gap) begin
            an_on = '0;
        end
    end

    assign blank  = src_lz && (idx_q != '0) && !nz;
    assign seg_on = blank ? 7'h00 : glyph(nib);
    assign dot_on = dsel && !blank;

    always_ff @(posedge clkIn or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
            pre_q   <= '0;
            idx_q   <= '0;
            num_q   <= '0;
            dots_q  <= '0;
            lz_q    <= 1'b0;
            seg_q   <= {7{POL}};
            dot_q   <= POL;
            an_q    <= {DIGITS{POL}};
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (!enable) begin
                pre_q  <= '0;
                idx_q  <= '0;
                num_q  <= '0;
                dots_q <= '0;
                lz_q   <= 1'b0;
                seg_q  <= {7{POL}};
                dot_q  <= POL;
                an_q   <= {DIGITS{POL}};
                tick_q <= 1'b0;
            end else begin
                if (load) begin
                    num_q  <= number;
                    dots_q <= dots;
                    lz_q   <= lz_blank;
                end
                if (pre_q == LAST_PRE) begin
                    pre_q <= '0;
                    idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                end else begin
                    pre_q <= pre_q + 1'b1;
                end
                seg_q  <= seg_on ^ {7{POL}};
                dot_q  <= dot_on ^ POL;
                an_q   <= an_on ^ {DIGITS{POL}};
                tick_q <= wrap;
            end
        end
    end

    assign disp.seven_segments = seg_q;
    assign disp.dot            = dot_q;
    assign disp.anodes         = an_q;
    assign disp.frame_tick     = tick_q;
endmodule

// File: tb/tb_sm_hex_display_mux.sv
// Directed self-checking bench for sm_hex_display_mux.
// Main DUT: 8 digits, prescale 4, blank 1; second DUT: 1 digit, prescale 2.
module tb_sm_hex_display_mux;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [31:0] number;
    logic [7:0]  dots;
    logic        lz_blank;
    logic [3:0]  number2;
    logic [0:0]  dots2;
    logic        lz2;

    int total = 0;
    int bad   = 0;

    logic [6:0] exp_seg [8];
    logic [7:0] ea;
    int s;
    int p;

    always #5 clk = ~clk;

    sm_hex_display_mux_if #(.DIGITS(8)) d1 ();
    sm_hex_display_mux_if #(.DIGITS(1)) d2 ();

    sm_hex_display_mux #(
        .DIGITS(8),
        .PRESCALE(4),
        .BLANK_CYCLES(1),
        .ACTIVE_LOW(1)
    ) dut1 (
        .clkIn(clk),
        .rst_n(rst_n),
        .enable(enable),
        .number(number),
        .dots(dots),
        .lz_blank(lz_blank),
        .disp(d1)
    );

    sm_hex_display_mux #(
        .DIGITS(1),
        .PRESCALE(2),
        .BLANK_CYCLES(0),
        .ACTIVE_LOW(1)
    ) dut2 (
        .clkIn(clk),
        .rst_n(rst_n),
        .enable(enable),
        .number(number2),
        .dots(dots2),
        .lz_blank(lz2),
        .disp(d2)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk_off(input string tag);
        chk({tag, "_an"}, 32'(d1.anodes), 32'hFF);
        chk({tag, "_seg"}, 32'(d1.seven_segments), 32'h7F);
        chk({tag, "_dot"}, 32'(d1.dot), 32'h1);
        chk({tag, "_ft"}, 32'(d1.frame_tick), 32'h0);
    endtask

    initial begin
        // glyphs (active-low) of 0x0123ABCD, digit 0 first
        exp_seg[0] = 7'h21;
        exp_seg[1] = 7'h46;
        exp_seg[2] = 7'h03;
        exp_seg[3] = 7'h08;
        exp_seg[4] = 7'h30;
        exp_seg[5] = 7'h24;
        exp_seg[6] = 7'h79;
        exp_seg[7] = 7'h40;

        rst_n    = 1'b0;
        enable   = 1'b1;
        number   = 32'h0123ABCD;
        dots     = 8'h00;
        lz_blank = 1'b0;
        number2  = 4'h5;
        dots2    = 1'b1;
        lz2      = 1'b1;
        cyc();
        cyc();
        chk_off("rst");
        chk("rst_an2", 32'(d2.anodes), 32'h1);
        rst_n = 1'b1;

        // frames 1-2: basic scan, glyphs, frame tick period
        for (int k = 1; k <= 64; k++) begin
            cyc();
            s  = ((k - 1) / 4) % 8;
            p  = (k - 1) % 4;
            ea = ~(8'h01 << s);
            if (p == 0) ea = 8'hFF;
            chk("t1_an", 32'(d1.anodes), 32'(ea));
            if (p != 0) chk("t1_seg", 32'(d1.seven_segments), 32'(exp_seg[s]));
            chk("t1_dot", 32'(d1.dot), 32'h1);
            chk("t1_ft", 32'(d1.frame_tick), 32'(k % 32 == 0));
            if (k <= 8) begin
                chk("t6_an", 32'(d2.anodes), 32'h0);
                chk("t6_seg", 32'(d2.seven_segments), 32'h12);
                chk("t6_dot", 32'(d2.dot), 32'h0);
                chk("t6_ft", 32'(d2.frame_tick), 32'(k % 2 == 0));
            end
        end

        // inputs change after the snapshot: frame 3 still shows old data
        number   = 32'h000000F0;
        lz_blank = 1'b1;
        dots     = 8'hFF;
        for (int k = 65; k <= 96; k++) begin
            cyc();
            s = (k - 65) / 4;
            p = (k - 65) % 4;
            if (p != 0) chk("t7_seg", 32'(d1.seven_segments), 32'(exp_seg[s]));
        end

        // frame 4: leading-zero blanking with dots requested everywhere
        for (int k = 97; k <= 128; k++) begin
            cyc();
            s  = (k - 97) / 4;
            p  = (k - 97) % 4;
            ea = ~(8'h01 << s);
            if (p == 0) ea = 8'hFF;
            chk("t2_an", 32'(d1.anodes), 32'(ea));
            if (p != 0) begin
                if (s >= 2) begin
                    chk("t2_seg", 32'(d1.seven_segments), 32'h7F);
                    chk("t2_dot", 32'(d1.dot), 32'h1);
                end else if (s == 1) begin
                    chk("t2_seg1", 32'(d1.seven_segments), 32'h0E);
                    chk("t2_dot1", 32'(d1.dot), 32'h0);
                end else begin
                    chk("t2_seg0", 32'(d1.seven_segments), 32'h40);
                    chk("t2_dot0", 32'(d1.dot), 32'h0);
                end
            end
            if (k == 110) begin
                number   = 32'h11111111;
                lz_blank = 1'b0;
                dots     = 8'h00;
            end
        end

        // frame 5: number changes during slot 3, no tearing
        for (int k = 129; k <= 160; k++) begin
            cyc();
            p = (k - 129) % 4;
            if (p != 0) chk("t3_seg1", 32'(d1.seven_segments), 32'h79);
            if (k == 142) number = 32'h22222222;
        end
        for (int k = 161; k <= 192; k++) begin
            cyc();
            p = (k - 161) % 4;
            if (p != 0) chk("t3_seg2", 32'(d1.seven_segments), 32'h24);
        end

        // enable dropped mid slot 5
        for (int k = 193; k <= 214; k++) cyc();
        chk("t4_pre_an", 32'(d1.anodes), 32'hDF);
        enable = 1'b0;
        cyc();
        chk_off("t4_off");
        cyc();
        cyc();
        chk_off("t4_off2");
        enable = 1'b1;
        for (int r = 1; r <= 32; r++) begin
            cyc();
            if (r == 1) chk("t4_r1_an", 32'(d1.anodes), 32'hFF);
            if (r == 2) begin
                chk("t4_r2_an", 32'(d1.anodes), 32'hFE);
                chk("t4_r2_seg", 32'(d1.seven_segments), 32'h24);
            end
            chk("t4_ft", 32'(d1.frame_tick), 32'(r == 32));
        end

        // asynchronous reset between edges
        cyc();
        cyc();
        chk("t5_pre_an", 32'(d1.anodes), 32'hFE);
        #2;
        rst_n = 1'b0;
        #1;
        chk_off("t5_async");
        chk("t5_an2", 32'(d2.anodes), 32'h1);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("t5_r1_an", 32'(d1.anodes), 32'hFF);
        cyc();
        chk("t5_r2_an", 32'(d1.anodes), 32'hFE);
        chk("t5_r2_seg", 32'(d1.seven_segments), 32'h24);
        chk("t5_r2_ft", 32'(d1.frame_tick), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
